// File: rtl/writeback_regfile_pkg.sv
// Shared processor definitions for the writeback stage: default widths and
// the memToReg source-select encoding.
package writeback_regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    WB_ALU     = 2'd0,
    WB_MEM     = 2'd1,
    WB_PCPP    = 2'd2,
    WB_ILLEGAL = 2'd3
  } wb_sel_e;

endpackage

// File: rtl/writeback_regfile_wb_select.sv
// Writeback source multiplexer: picks the value a committing instruction
// writes back, forcing zero for the illegal encoding.
module wb_select
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [1:0]        sel_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] mem_i,
  input  logic [DATA_W-1:0] pcpp_i,
  output logic [DATA_W-1:0] data_o
);

  // Source select
  always_comb begin
    data_o = '0;
    case (wb_sel_e'(sel_i))
      WB_ALU:     data_o = alu_i;
      WB_MEM:     data_o = mem_i;
      WB_PCPP:    data_o = pcpp_i;
      WB_ILLEGAL: data_o = '0;
      default:    data_o = '0;
    endcase
  end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage register file: 2 read / 1 write ports with same-cycle
// write-through bypass, a committed-write counter and a sticky illegal flag.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] DataOutDataMemory,
  input  logic [1:0]        memToReg,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [ADDR_W-1:0] registerFileWrite,
  input  logic              regWrite,
  input  logic [DATA_W-1:0] pcpp,
  input  logic [ADDR_W-1:0] readAddrA,
  input  logic [ADDR_W-1:0] readAddrB,
  output logic [DATA_W-1:0] readDataA,
  output logic [DATA_W-1:0] readDataB,
  output logic [DATA_W-1:0] writeData,
  output logic              writeValid,
  output logic [31:0]       writeCount,
  output logic              illegalSel
);

  localparam int REG_N = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [REG_N];
  logic [31:0]       count_q, count_d;
  logic              illegal_q, illegal_d;
  logic              illegal_req;

  wb_select #(.DATA_W(DATA_W)) u_wb_select (
    .sel_i  (memToReg),
    .alu_i  (ALUResult),
    .mem_i  (DataOutDataMemory),
    .pcpp_i (pcpp),
    .data_o (writeData)
  );

  // Register 0 is hardwired, so a write aimed at it never commits
  assign writeValid  = regWrite && (wb_sel_e'(memToReg) != WB_ILLEGAL) &&
                       (registerFileWrite != '0) && !reset;
  assign illegal_req = regWrite && (wb_sel_e'(memToReg) == WB_ILLEGAL);

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored
  );
    if (addr == '0) begin
      return '0;
    end else if (writeValid && (addr == registerFileWrite)) begin
      return writeData;
    end else begin
      return stored;
    end
  endfunction

  // Read ports with zero register and write-through bypass
  always_comb begin
    readDataA = read_port(readAddrA, regs_q[readAddrA]);
    readDataB = read_port(readAddrB, regs_q[readAddrB]);
  end

  // Next-state for the commit counter and sticky flag
  always_comb begin
    count_d   = count_q;
    illegal_d = illegal_q;
    if (writeValid) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
    if (illegal_req) begin
      illegal_d = 1'b1;
    end else begin
      illegal_d = illegal_q;
    end
  end

  // Register storage, counter and flag state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) begin
        regs_q[i] <= '0;
      end
      count_q   <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      if (writeValid) begin
        regs_q[registerFileWrite] <= writeData;
      end
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  assign writeCount = count_q;
  assign illegalSel = illegal_q;

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter DATA_W, default 32, datapath width of every data port and register.
REQ-002 Parameter ADDR_W, default 4, register address width; register count = 2^ADDR_W (16).
REQ-003 Port clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port DataOutDataMemory  input  DATA_W  load data from the MEM/WB stage register.
REQ-006 Port memToReg  input  2  writeback source select: 0 = ALUResult, 1 = DataOutDataMemory, 2 = pcpp, 3 = illegal.
REQ-007 Port ALUResult  input  DATA_W  ALU result from the MEM/WB stage register.
REQ-008 Port registerFileWrite  input  ADDR_W  destination register index.
REQ-009 Port regWrite  input  1  write enable from the MEM/WB stage register.
REQ-010 Port pcpp  input  DATA_W  PC+4 value for link writes.
REQ-011 Port readAddrA / readAddrB  input  ADDR_W each  decode-stage read indices.
REQ-012 Port readDataA / readDataB  output  DATA_W each  read data, combinational.
REQ-013 Port writeData  output  DATA_W  selected writeback value, combinational, for EX-stage forwarding.
REQ-014 Port writeValid  output  1  high when a register write commits at the next rising edge.
REQ-015 Port writeCount  output  32  number of committed register writes since reset.
REQ-016 Port illegalSel  output  1  sticky flag: memToReg == 3 seen with regWrite high.

Function
REQ-017 writeData SHALL equal the memToReg-selected source; for memToReg == 3 it SHALL be 0.
REQ-018 writeValid SHALL equal regWrite AND (memToReg != 3) AND (registerFileWrite != 0) AND NOT reset.
REQ-019 On a rising edge with writeValid high, register[registerFileWrite] SHALL load writeData; no other register changes.
REQ-020 Register 0 SHALL never be written and SHALL always read 0.
REQ-021 readDataX SHALL be 0 when readAddrX == 0.
REQ-022 Otherwise, when writeValid is high and readAddrX == registerFileWrite, readDataX SHALL be writeData (same-cycle write-through bypass).
REQ-023 Otherwise readDataX SHALL be the stored register value.
REQ-024 Both read ports SHALL operate independently; identical addresses on both ports SHALL return identical data.
REQ-025 writeCount SHALL increment by 1 on each rising edge with writeValid high, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-026 illegalSel SHALL be set on a rising edge with regWrite high and memToReg == 3, and SHALL hold until reset.
REQ-027 An illegal-select cycle SHALL NOT write any register and SHALL NOT increment writeCount.
REQ-028 Write latency: a value written at edge N SHALL be visible from storage after edge N, and through the bypass during the cycle before edge N.

Reset
REQ-029 Asserting reset SHALL clear all registers, writeCount and illegalSel to 0 immediately, independent of clock.
REQ-030 While reset is high, no write SHALL occur and writeValid SHALL be 0.
REQ-031 Reset asserted in the same cycle as a pending write SHALL discard that write.
REQ-032 After reset deasserts, the first rising edge SHALL accept writes normally.

Structure
REQ-033 The memToReg encodings (WB_ALU = 0, WB_MEM = 1, WB_PCPP = 2, WB_ILLEGAL = 3) and DATA_W/ADDR_W defaults SHALL live in the shared processor package.
REQ-034 The source select (REQ-017) SHALL be one sub-module, wb_select; storage, bypass, counter and flag SHALL stay in writeback_regfile.

Verification
REQ-035 Reset, then read all 16 addresses on both ports -> all 0; writeCount = 0; illegalSel = 0.
REQ-036 regWrite = 1, memToReg = 0, ALUResult = 0xDEADBEEF, registerFileWrite = 5, readAddrA = 5 -> readDataA = 0xDEADBEEF before the edge (bypass) and after it (stored); writeCount = 1.
REQ-037 Write 0x12345678 with memToReg = 1 to register 0 -> readDataA(0) = 0; writeValid = 0; writeCount unchanged.
REQ-038 memToReg = 2, pcpp = 0x00000040, registerFileWrite = 15; then memToReg = 3, registerFileWrite = 15, ALUResult = 0xFFFFFFFF -> register 15 stays 0x00000040; illegalSel = 1 and sticky; writeCount advances only once.
REQ-039 Assert reset asynchronously mid-cycle while a write to register 3 is pending -> register 3 = 0, writeCount = 0, illegalSel = 0 without waiting for a clock edge.
REQ-040 Preload writeCount to 0xFFFFFFFF (force), then one valid write -> writeCount = 0.
